// File: rtl/sum_accum.sv
`default_nettype none
// ============================================================================
// Module   : sum_accum
// Purpose  : Accumulates {cout,sum} beats from an upstream adder over a
//            start/len-delimited run and holds the total until it is taken.
// Revision : 1.0
// ============================================================================
module sum_accum #(
    parameter int WIDTH = 65,
    parameter int GUARD = 8,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CNT_W-1:0]           len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_sum,
    input  logic                       in_cout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH+GUARD:0]       out_acc,
    output logic                       out_ovf,
    output logic [CNT_W-1:0]           out_count,
    output logic                       busy
);

    localparam int AW = WIDTH + 1 + GUARD;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  len_q, len_d;

    logic [AW-1:0]     w_beat;
    logic [AW:0]       w_sum;
    logic [CNT_W-1:0]  w_count_inc;

    always_comb begin
        w_beat            = '0;
        w_beat[WIDTH:0]   = {in_cout, in_sum};
    end

    // Extra top bit of w_sum captures the carry out of the accumulator MSB.
    assign w_sum       = {1'b0, acc_q} + {1'b0, w_beat};
    assign w_count_inc = count_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = '0;
                    len_d   = len;
                    state_d = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d   = w_sum[AW-1:0];
                    ovf_d   = ovf_q | w_sum[AW];
                    count_d = w_count_inc;
                    if (w_count_inc == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_accum
// Purpose  : Directed self-checking bench for sum_accum (default and 6-bit acc).
// Revision : 1.0
// ============================================================================
module tb_sum_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Default-parameter instance
    logic        start, in_valid, in_cout, out_ready;
    logic [7:0]  len;
    logic [64:0] in_sum;
    logic        in_ready, out_valid, out_ovf, busy;
    logic [73:0] out_acc;
    logic [7:0]  out_count;

    // WIDTH=4, GUARD=1 instance
    logic        s_start, s_valid, s_cout, s_oready;
    logic [7:0]  s_len;
    logic [3:0]  s_sum;
    logic        s_iready, s_ovalid, s_ovf, s_busy;
    logic [5:0]  s_acc;
    logic [7:0]  s_cnt;

    sum_accum dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_ovf(out_ovf), .out_count(out_count), .busy(busy)
    );

    sum_accum #(.WIDTH(4), .GUARD(1), .CNT_W(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .len(s_len),
        .in_valid(s_valid), .in_ready(s_iready), .in_sum(s_sum), .in_cout(s_cout),
        .out_valid(s_ovalid), .out_ready(s_oready), .out_acc(s_acc),
        .out_ovf(s_ovf), .out_count(s_cnt), .busy(s_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; len = 0; in_valid = 0; in_cout = 0; in_sum = '0; out_ready = 0;
        s_start = 0; s_len = 0; s_valid = 0; s_cout = 0; s_sum = '0; s_oready = 0;
        #3;
        n_checks++;
        if ({busy, in_ready, out_valid, out_ovf, out_count, out_acc} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b rdy=%b vld=%b ovf=%b cnt=%0d acc=%0h required all 0",
                     busy, in_ready, out_valid, out_ovf, out_count, out_acc);
        end
        tick();
        tick();
        rst_n = 1'b1;
        start = 1; len = 8'd1;
        tick();
        start = 0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL first_start: busy=%b in_ready=%b required 1 1", busy, in_ready);
        end
        in_valid = 1; in_sum = 65'd4;
        tick();
        in_valid = 0; out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_basic();
        logic [73:0] exp_acc;
        exp_acc = (74'd1 << 65) + 74'd12;
        start = 1; len = 8'd3;
        tick();
        start = 0;
        n_checks++;
        if (out_acc !== 74'd0 || out_count !== 8'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_clear: acc=%0h cnt=%0d rdy=%b required 0 0 1", out_acc, out_count, in_ready);
        end
        in_valid = 1; in_cout = 0; in_sum = 65'd5;
        tick();
        in_sum = 65'd7;
        tick();
        n_checks++;
        if (out_acc !== 74'd12 || out_count !== 8'd2 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_partial: acc=%0h cnt=%0d vld=%b required c 2 0", out_acc, out_count, out_valid);
        end
        in_cout = 1; in_sum = '0;
        tick();
        in_valid = 0; in_cout = 0;
        n_checks++;
        if (out_valid !== 1'b1 || out_acc !== exp_acc || out_count !== 8'd3 || out_ovf !== 1'b0
            || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: vld=%b acc=%0h cnt=%0d ovf=%b rdy=%b required 1 %0h 3 0 0",
                     out_valid, out_acc, out_count, out_ovf, in_ready, exp_acc);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: busy=%b vld=%b required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_len_zero();
        start = 1; len = 8'd0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_ready_idle: in_ready=%b required 0", in_ready);
        end
        tick();
        start = 0;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_acc !== 74'd0 || out_count !== 8'd0
            || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_done: vld=%b rdy=%b acc=%0h cnt=%0d ovf=%b required 1 0 0 0 0",
                     out_valid, in_ready, out_acc, out_count, out_ovf);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_idle: busy=%b rdy=%b required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_wrap();
        s_start = 1; s_len = 8'd3;
        tick();
        s_start = 0;
        s_valid = 1; s_cout = 1; s_sum = 4'hF;
        tick();
        tick();
        n_checks++;
        if (s_acc !== 6'd62 || s_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_partial: acc=%0d ovf=%b required 62 0", s_acc, s_ovf);
        end
        tick();
        s_valid = 0;
        n_checks++;
        if (s_acc !== 6'd29 || s_ovf !== 1'b1 || s_cnt !== 8'd3 || s_ovalid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_result: acc=%0d ovf=%b cnt=%0d vld=%b required 29 1 3 1",
                     s_acc, s_ovf, s_cnt, s_ovalid);
        end
        s_oready = 1;
        tick();
        s_oready = 0;
        s_start = 1; s_len = 8'd1;
        tick();
        s_start = 0;
        n_checks++;
        if (s_ovf !== 1'b0 || s_acc !== 6'd0) begin
            n_fail++;
            $display("FAIL wrap_ovf_clear: ovf=%b acc=%0d required 0 0", s_ovf, s_acc);
        end
        s_valid = 1; s_cout = 0; s_sum = 4'd3;
        tick();
        s_valid = 0; s_oready = 1;
        tick();
        s_oready = 0;
    endtask

    task automatic test_back_to_back();
        start = 1; len = 8'd2;
        tick();
        start = 0;
        in_valid = 1; in_sum = 65'd10;
        tick();
        in_valid = 0; in_sum = 65'd99;
        tick();
        n_checks++;
        if (out_count !== 8'd1 || out_acc !== 74'd10) begin
            n_fail++;
            $display("FAIL bp_gap: cnt=%0d acc=%0d required 1 10", out_count, out_acc);
        end
        in_valid = 1; in_sum = 65'd20;
        tick();
        for (int i = 0; i < 5; i++) begin
            in_sum = 65'd100 + 65'(i);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_acc !== 74'd30 || out_count !== 8'd2 || out_ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: vld=%b acc=%0d cnt=%0d ovf=%b required 1 30 2 0",
                         i, out_valid, out_acc, out_count, out_ovf);
            end
        end
        out_ready = 1; start = 1; len = 8'd5;
        tick();
        out_ready = 0; start = 0;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: busy=%b vld=%b required 0 0", busy, out_valid);
        end
        tick();
        tick();
        in_valid = 0;
        n_checks++;
        if (busy !== 1'b0 || out_acc !== 74'd30 || out_count !== 8'd2) begin
            n_fail++;
            $display("FAIL bp_idle_stable: busy=%b acc=%0d cnt=%0d required 0 30 2", busy, out_acc, out_count);
        end
    endtask

    task automatic test_reset_midrun();
        start = 1; len = 8'd4;
        tick();
        start = 0;
        in_valid = 1; in_sum = 65'd1;
        tick();
        in_sum = 65'd2;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, in_ready, out_valid, out_ovf, out_count, out_acc} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: busy=%b rdy=%b vld=%b ovf=%b cnt=%0d acc=%0h required all 0",
                     busy, in_ready, out_valid, out_ovf, out_count, out_acc);
        end
        in_valid = 0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_sum = 65'd3;
            tick();
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_no_valid%0d: vld=%b busy=%b required 0 0", i, out_valid, busy);
            end
        end
        in_valid = 0;
        start = 1; len = 8'd1;
        tick();
        start = 0;
        in_valid = 1; in_sum = 65'd9;
        tick();
        in_valid = 0;
        n_checks++;
        if (out_valid !== 1'b1 || out_acc !== 74'd9 || out_count !== 8'd1) begin
            n_fail++;
            $display("FAIL midrun_newrun: vld=%b acc=%0d cnt=%0d required 1 9 1", out_valid, out_acc, out_count);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_start_ignored();
        start = 1; len = 8'd2;
        tick();
        len = 8'd5;
        in_valid = 1; in_sum = 65'd3;
        tick();
        in_sum = 65'd4;
        tick();
        start = 0; in_valid = 0;
        n_checks++;
        if (out_valid !== 1'b1 || out_count !== 8'd2 || out_acc !== 74'd7) begin
            n_fail++;
            $display("FAIL start_ignored: vld=%b cnt=%0d acc=%0d required 1 2 7", out_valid, out_count, out_acc);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_back_to_back();
        test_reset_midrun();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
